// File: rtl/booth_seq_mul.sv
// ---------------------------------------------------------------------------
// booth_seq_mul
//
// Iterative radix-2 Booth multiplier. It performs one Booth step per clock
// and has a start/busy/done handshake. Each operation selects signed or
// unsigned operands. The result is 2*WIDTH bits wide, so it maps straight
// onto HI/LO.
//
// Operands are widened by one bit to N = WIDTH+1:
//   - sign extension in signed mode,
//   - zero extension in unsigned mode.
// The product is then a signed N x N product, so full-range unsigned inputs
// and the most-negative signed inputs come out exact. The accumulator
// carries one further guard bit, so A +/- M cannot overflow.
//
// Timing (E0 = edge that accepts start):
//   - Booth steps run on E1..EN.
//   - done and the new product are visible after EN.
//   - busy and done fall after EN+1.
//   - The next start can be accepted at EN+2.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request a multiply (sampled only while idle)
//   signed_mode  in   1 = two's-complement operands, 0 = unsigned
//   a            in   [WIDTH-1:0] multiplier operand (captured with start)
//   b            in   [WIDTH-1:0] multiplicand operand (captured with start)
//   busy         out  high from the accepting edge until back in idle
//   done         out  one-cycle pulse, product valid in that cycle
//   product      out  [2*WIDTH-1:0] registered result, held until next done
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module booth_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N     = WIDTH + 1;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (WIDTH < 4) begin : g_width_check
        $error("booth_seq_mul: WIDTH must be at least 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_e               state_q,   state_d;
    logic [N-1:0]         m_q,       m_d;        // multiplicand, extended b
    logic [N-1:0]         q_q,       q_d;        // multiplier, extended a
    logic                 qm1_q,     qm1_d;      // Booth look-behind bit q(-1)
    logic [N:0]           acc_q,     acc_d;      // accumulator with guard bit
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    // -----------------------------------------------------------------------
    // Operand extension: the extra top bit is the sign bit in signed mode
    // and 0 in unsigned mode.
    // -----------------------------------------------------------------------
    logic [N-1:0] a_ext;
    logic [N-1:0] b_ext;

    assign a_ext = {signed_mode & a[WIDTH-1], a};
    assign b_ext = {signed_mode & b[WIDTH-1], b};

    // -----------------------------------------------------------------------
    // One Booth step. It is computed every cycle but only committed in RUN.
    // -----------------------------------------------------------------------
    logic [N:0]           m_wide;      // M sign-extended to accumulator width
    logic [N:0]           acc_sum;     // accumulator after add/sub
    logic [N:0]           acc_shift;   // accumulator after arithmetic shift
    logic [N-1:0]         q_shift;     // multiplier after shift
    logic [2*WIDTH-1:0]   step_product;

    assign m_wide = {m_q[N-1], m_q};

    always_comb begin
        unique case ({q_q[0], qm1_q})
            2'b10:   acc_sum = acc_q - m_wide;
            2'b01:   acc_sum = acc_q + m_wide;
            default: acc_sum = acc_q;
        endcase
    end

    // Arithmetic right shift of {A, Q, q(-1)}: A's MSB is replicated, A's
    // LSB drops into Q, and Q's LSB becomes the new q(-1).
    assign acc_shift = {acc_sum[N], acc_sum[N:1]};
    assign q_shift   = {acc_sum[0], q_q[N-1:1]};

    // The low 2*WIDTH bits of the shifted {A, Q} are {acc_sum[WIDTH-1:0],
    // q_q[N-1:1]}. They are taken straight from the pre-shift values so the
    // discarded top bits never need a name.
    assign step_product = {acc_sum[WIDTH-1:0], q_q[N-1:1]};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets a default before the case. A path that does
        // not assign a signal then holds it instead of inferring a latch.
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    m_d     = b_ext;
                    q_d     = a_ext;
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                acc_d = acc_shift;
                q_d   = q_shift;
                qm1_d = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    product_d = step_product;
                end
            end

            // Start requests seen here are dropped, not queued.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags are registered copies of the next state, so busy and done
        // come straight from flops.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. All flops
        // then update together from values sampled before the edge.
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mul
//
// Directed test of booth_seq_mul at WIDTH=16 and WIDTH=8. The DUTs share
// one clock and one reset. Inputs are driven and outputs sampled on the
// falling edge. Expected products are hand-computed constants (WIDTH=16)
// or integer multiplication of the same operands (WIDTH=8).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_booth_seq_mul;

    logic clk = 1'b0;
    logic rst;

    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic [15:0] prev8;   // last product the WIDTH=8 DUT should be holding

    int n_checks = 0;
    int n_errors = 0;

    booth_seq_mul #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .signed_mode (sm16),
        .a           (a16),
        .b           (b16),
        .busy        (busy16),
        .done        (done16),
        .product     (prod16)
    );

    booth_seq_mul #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .product     (prod8)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=16 multiply. The call starts at a falling edge with the DUT
    // idle. The operands are scrambled after the capture edge. Latency,
    // busy length, the product and the done fall are all checked.
    task automatic mul16(input string tag, input logic sm,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp);
        int  lat;
        int  busy_cnt;
        bit  seen;
        sm16    = sm;
        a16     = av;
        b16     = bv;
        start16 = 1'b1;
        @(negedge clk);                  // E0 has happened
        start16 = 1'b0;
        a16     = ~av;
        b16     = bv ^ 16'h5A5A;
        sm16    = ~sm;
        lat      = -1;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (busy16) busy_cnt++;
            if (done16) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, lat, 17);
        check({tag, "_product"}, prod16, exp);
        @(negedge clk);
        check({tag, "_busy_cycles"}, busy_cnt, 18);
        check({tag, "_busy_fall"}, busy16, 0);
        check({tag, "_done_fall"}, done16, 0);
        check({tag, "_product_hold"}, prod16, exp);
    endtask

    // One WIDTH=8 multiply with a reference product from integer arithmetic.
    task automatic mul8(input logic sm, input logic [7:0] av,
                        input logic [7:0] bv);
        int          ai;
        int          bi;
        logic [31:0] p;
        logic [15:0] exp;
        int          lat;
        bit          seen;
        ai  = sm ? int'($signed(av)) : int'(av);
        bi  = sm ? int'($signed(bv)) : int'(bv);
        p   = ai * bi;
        exp = p[15:0];
        check("w8_hold_idle", prod8, prev8);
        sm8    = sm;
        a8     = av;
        b8     = bv;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        sm8    = ~sm;
        seen   = 1'b0;
        lat    = -1;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (done8) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                check("w8_hold_run", prod8, prev8);
                @(negedge clk);
            end
        end
        check("w8_done_seen", seen, 1);
        check("w8_latency", lat, 9);
        check("w8_product", prod8, exp);
        prev8 = exp;
        @(negedge clk);
        check("w8_done_pulse", done8, 0);
    endtask

    initial begin
        int done_cnt;
        int first_n;
        int second_n;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] edge_vals [4];

        rst     = 1'b1;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
        prev8   = '0;
        edge_vals[0] = 8'h00; edge_vals[1] = 8'h80;
        edge_vals[2] = 8'h7F; edge_vals[3] = 8'hFF;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy16, 0);
        check("reset_done", done16, 0);
        check("reset_product", prod16, 0);
        check("reset_product_w8", prod8, 0);

        // Directed WIDTH=16 vectors
        mul16("signed_small",   1'b1, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1);
        mul16("signed_minmin",  1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        mul16("signed_minmax",  1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000);
        mul16("signed_m1m1",    1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
        mul16("unsigned_max",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        mul16("unsigned_shift", 1'b0, 16'h8000, 16'h0002, 32'h0001_0000);
        mul16("zero_operand",   1'b1, 16'h0000, 16'h1234, 32'h0000_0000);

        // Handshake. Start is re-pulsed with new operands mid-RUN (n=3) and
        // in the DONE cycle (n=17), and both are dropped. The pulse at
        // n=18 lands on EN+2 and must be accepted.
        sm16 = 1'b1; a16 = 16'd7; b16 = 16'd9; start16 = 1'b1;
        @(negedge clk);
        done_cnt = 0; first_n = -1; second_n = -1;
        for (int n = 0; n < 46; n++) begin
            if (done16) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_n = n;
                    check("hs_product_first", prod16, 63);
                end else if (done_cnt == 2) begin
                    second_n = n;
                    check("hs_product_second", prod16, 10000);
                end
            end
            a16     = 16'd100;
            b16     = 16'd100;
            start16 = (n == 3 || n == 17 || n == 18);
            @(negedge clk);
        end
        start16 = 1'b0;
        check("hs_done_count", done_cnt, 2);
        check("hs_first_at", first_n, 17);
        check("hs_second_at", second_n, 36);

        // Reset five cycles into RUN: the operation is dropped and no done
        // follows.
        sm16 = 1'b1; a16 = 16'd1234; b16 = 16'd56; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy16, 0);
        check("midrst_done", done16, 0);
        check("midrst_product", prod16, 0);
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            if (done16) done_cnt++;
            @(negedge clk);
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_product_hold", prod16, 0);
        mul16("after_reset", 1'b1, 16'd10, 16'hFFF6, 32'hFFFF_FF9C);

        // WIDTH=8: both modes, random operands with regular edge values
        prev8 = '0;
        for (int i = 0; i < 1000; i++) begin
            ea = 8'($urandom);
            eb = 8'($urandom);
            if (i % 5 == 0) begin
                ea = edge_vals[$urandom_range(0, 3)];
                eb = edge_vals[$urandom_range(0, 3)];
            end
            mul8(1'(i % 2), ea, eb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
